roce_tx_arbiter: RTL and testbench
==================================

ROCE_TX_ARBITER -- requirements
Module: roce_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning payload tdata width.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, meaning payload tkeep width.
REQ-003 SHALL have parameter HDR_WIDTH, default ROCE_HDR_W from package, meaning packed BTH+RETH+IP/UDP header word width.
REQ-004 SHALL have one clock and a synchronous, active-low reset; all logic is clocked on the rising edge of clk.
REQ-005 Ports:
 - clk  in  1  clock.
 - resetn  in  1  synchronous active-low reset.
 - s_hdr_valid  in  2  per-requester header valid; port 0 is the data path, port 1 is the ACK generator.
 - s_hdr_ready  out  2  per-requester header ready.
 - s_hdr_data  in  2*HDR_WIDTH  packed headers; port n occupies [n*HDR_WIDTH +: HDR_WIDTH].
 - s_axis_tdata  in  2*DATA_WIDTH  payload data per port.
 - s_axis_tkeep  in  2*KEEP_WIDTH  payload keep per port.
 - s_axis_tvalid / s_axis_tlast / s_axis_tuser  in  2 each  payload handshake and sideband per port.
 - s_axis_tready  out  2  payload ready per port.
 - m_hdr_valid  out  1; m_hdr_ready  in  1; m_hdr_data  out  HDR_WIDTH  header toward the RoCE UDP TX block.
 - m_axis_tdata/tkeep/tvalid/tlast/tuser  out  DATA_WIDTH/KEEP_WIDTH/1/1/1; m_axis_tready  in  1  payload toward the RoCE UDP TX block.
 - grant  out  2  one-hot owner of the current frame, 0 when idle.
 - busy  out  1  high in any state other than IDLE.
 - frame_cnt  out  2*16  completed frames per port, wraps.

Function
REQ-006 SHALL run an FSM with states IDLE, HDR, PAYLOAD.
REQ-007 In IDLE with any s_hdr_valid high, the block SHALL select a port by round-robin pointer rr, pulse that port's s_hdr_ready for one cycle, latch its header into m_hdr_data, set grant, and go to HDR.
REQ-008 When both ports request in the same IDLE cycle, the block SHALL grant port rr; rr resets to 0.
REQ-009 In HDR the block SHALL hold m_hdr_valid=1 with a stable m_hdr_data until m_hdr_ready=1, then go to PAYLOAD; header-to-output latency SHALL be 1 cycle after the input handshake.
REQ-010 In PAYLOAD the granted port's payload SHALL be muxed combinationally to m_axis_*; s_axis_tready[g] = m_axis_tready; the other port's tready = 0; m_axis_tvalid = 0 outside PAYLOAD.
REQ-011 A beat with m_axis_tvalid & m_axis_tready & m_axis_tlast SHALL end the frame: increment frame_cnt[g] mod 2^16, set rr to the other port, clear grant, and return to IDLE.
REQ-012 The IDLE-to-IDLE gap SHALL be at least one cycle, so a new header is accepted no sooner than the cycle after the tlast handshake.
REQ-013 s_hdr_ready SHALL never be high outside IDLE, and never high for more than one port.
REQ-014 Payload presented by a non-granted port SHALL be stalled, never dropped; headers that arrive during PAYLOAD SHALL wait.
REQ-015 Every frame SHALL carry at least one payload beat; tuser SHALL pass through unmodified.

Reset
REQ-016 While resetn=0 at a clock edge, the block SHALL set state=IDLE, rr=0, grant=0, busy=0, m_hdr_valid=0, m_hdr_data=0, s_hdr_ready=0, frame_cnt=0; m_axis_tvalid and s_axis_tready SHALL then be 0.
REQ-017 A reset mid-frame SHALL abandon the frame without emitting tlast; the next frame after reset SHALL start from IDLE.

Structure
REQ-018 Package roce_pkg SHALL hold ROCE_HDR_W, the header field offsets, and the state enum.
REQ-019 Round-robin select and pointer update SHALL live in one sub-module, rr_arb2.

Verification
REQ-020 Only port 0 sends a 3-beat frame with m_axis_tready=1 -> header out 1 cycle after accept, 3 beats out in order, grant=01, frame_cnt[0]=1.
REQ-021 Both ports assert headers in the same cycle after reset -> port 0 is served first, then port 1; rr ends at 0.
REQ-022 Port 0 makes back-to-back requests while port 1 is pending -> the grants alternate 0,1,0.
REQ-023 m_axis_tready toggles 0/1 during a 32-beat frame ending with tkeep=64'h000000FFFFFFFFFF -> no beat is lost or duplicated, and the last tkeep matches.
REQ-024 m_hdr_ready is held 0 for 5 cycles -> m_hdr_valid and m_hdr_data stay stable, and s_axis_tready=00.
REQ-025 resetn=0 at beat 10 of 32 -> all outputs are 0 on the next edge; the next frame completes normally.

Source files
------------

// File: rtl/roce_pkg.sv
// Shared definitions for the RoCE transmit arbiter: header layout, FSM states
// and a small one-hot helper.
package roce_pkg;

   localparam int BTH_OFFSET  = 0;
   localparam int BTH_W       = 96;
   localparam int RETH_OFFSET = BTH_OFFSET + BTH_W;
   localparam int RETH_W      = 128;
   localparam int UDP_OFFSET  = RETH_OFFSET + RETH_W;
   localparam int UDP_W       = 64;
   localparam int IP_OFFSET   = UDP_OFFSET + UDP_W;
   localparam int IP_W        = 160;
   localparam int ROCE_HDR_W  = IP_OFFSET + IP_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2
   } arb_state_t;

   function automatic logic [1:0] portOneHot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin selector; the pointer moves past the owner of
// each completed frame.
module rr_arb2
   import roce_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [1:0] i_req,
   input  logic       i_update,
   input  logic       i_owner,
   output logic       o_valid,
   output logic       o_selIdx,
   output logic [1:0] o_selOneHot
);

   logic r_rr;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rr <= 1'b0;
      end else if (i_update) begin
         r_rr <= ~i_owner;
      end
   end

   // The port under the pointer wins a tie; otherwise whichever port asks.
   always_comb begin
      o_valid     = |i_req;
      o_selIdx    = i_req[r_rr] ? r_rr : ~r_rr;
      o_selOneHot = portOneHot(o_selIdx);
   end

endmodule

// File: rtl/roce_tx_arbiter.sv
// Arbitrates header+payload frames from the data path (port 0) and the ACK
// generator (port 1) onto a single RoCE UDP TX stream.
module roce_tx_arbiter
   import roce_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int HDR_WIDTH  = ROCE_HDR_W
)
(
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [1:0]              s_hdr_valid,
   output logic [1:0]              s_hdr_ready,
   input  logic [2*HDR_WIDTH-1:0]  s_hdr_data,
   input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [2*KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [1:0]              s_axis_tvalid,
   input  logic [1:0]              s_axis_tlast,
   input  logic [1:0]              s_axis_tuser,
   output logic [1:0]              s_axis_tready,
   output logic                    m_hdr_valid,
   input  logic                    m_hdr_ready,
   output logic [HDR_WIDTH-1:0]    m_hdr_data,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tuser,
   input  logic                    m_axis_tready,
   output logic [1:0]              grant,
   output logic                    busy,
   output logic [31:0]             frame_cnt
);

   arb_state_t             r_state;
   arb_state_t             w_nextState;
   logic [1:0]             r_grant;
   logic [HDR_WIDTH-1:0]   r_hdrData;
   logic [15:0]            r_frameCnt [2];

   logic                   w_anyReq;
   logic                   w_selIdx;
   logic [1:0]             w_selOneHot;
   logic                   w_hdrTake;
   logic                   w_ownerIdx;
   logic                   w_frameEnd;
   logic                   w_inPayload;

   rr_arb2 u_rrArb (
      .clk         (clk),
      .resetn      (resetn),
      .i_req       (s_hdr_valid),
      .i_update    (w_frameEnd),
      .i_owner     (w_ownerIdx),
      .o_valid     (w_anyReq),
      .o_selIdx    (w_selIdx),
      .o_selOneHot (w_selOneHot)
   );

   assign w_ownerIdx  = r_grant[1];
   assign w_inPayload = (r_state == ST_PAYLOAD);
   assign w_hdrTake   = (r_state == ST_IDLE) && resetn && w_anyReq;
   assign w_frameEnd  = m_axis_tvalid && m_axis_tready && m_axis_tlast;

   // Header ready is gated by resetn so no handshake can slip in at a reset edge.
   always_comb begin
      w_nextState = r_state;
      s_hdr_ready = 2'b00;
      m_hdr_valid = 1'b0;
      busy        = 1'b1;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (w_anyReq) begin
               w_nextState = ST_HDR;
               if (resetn) begin
                  s_hdr_ready = w_selOneHot;
               end
            end
         end
         ST_HDR: begin
            m_hdr_valid = 1'b1;
            if (m_hdr_ready) begin
               w_nextState = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (w_frameEnd) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      s_axis_tready = 2'b00;
      if (w_inPayload) begin
         m_axis_tdata  = w_ownerIdx ? s_axis_tdata[DATA_WIDTH +: DATA_WIDTH]
                                    : s_axis_tdata[0 +: DATA_WIDTH];
         m_axis_tkeep  = w_ownerIdx ? s_axis_tkeep[KEEP_WIDTH +: KEEP_WIDTH]
                                    : s_axis_tkeep[0 +: KEEP_WIDTH];
         m_axis_tvalid = s_axis_tvalid[w_ownerIdx];
         m_axis_tlast  = s_axis_tlast[w_ownerIdx];
         m_axis_tuser  = s_axis_tuser[w_ownerIdx];
         s_axis_tready = m_axis_tready ? r_grant : 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state       <= ST_IDLE;
         r_grant       <= 2'b00;
         r_hdrData     <= '0;
         r_frameCnt[0] <= 16'd0;
         r_frameCnt[1] <= 16'd0;
      end else begin
         r_state <= w_nextState;
         if (w_hdrTake) begin
            r_grant   <= w_selOneHot;
            r_hdrData <= w_selIdx ? s_hdr_data[HDR_WIDTH +: HDR_WIDTH]
                                  : s_hdr_data[0 +: HDR_WIDTH];
         end else if (w_frameEnd) begin
            r_grant                <= 2'b00;
            r_frameCnt[w_ownerIdx] <= r_frameCnt[w_ownerIdx] + 16'd1;
         end
      end
   end

   assign m_hdr_data = r_hdrData;
   assign grant      = r_grant;
   assign frame_cnt  = {r_frameCnt[1], r_frameCnt[0]};

endmodule

// File: tb/tb_roce_tx_arbiter.sv
// Randomized bench for roce_tx_arbiter: two frame sources feed the DUT and a
// frame-level reference model predicts every output cycle by cycle.
module tb_roce_tx_arbiter;
   import roce_pkg::*;

   localparam int DW = 512;
   localparam int KW = DW / 8;
   localparam int HW = ROCE_HDR_W;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic          user;
   } beat_t;

   logic            clk = 1'b0;
   logic            resetn;
   logic [1:0]      s_hdr_valid;
   logic [1:0]      s_hdr_ready;
   logic [2*HW-1:0] s_hdr_data;
   logic [2*DW-1:0] s_axis_tdata;
   logic [2*KW-1:0] s_axis_tkeep;
   logic [1:0]      s_axis_tvalid;
   logic [1:0]      s_axis_tlast;
   logic [1:0]      s_axis_tuser;
   logic [1:0]      s_axis_tready;
   logic            m_hdr_valid;
   logic            m_hdr_ready;
   logic [HW-1:0]   m_hdr_data;
   logic [DW-1:0]   m_axis_tdata;
   logic [KW-1:0]   m_axis_tkeep;
   logic            m_axis_tvalid;
   logic            m_axis_tlast;
   logic            m_axis_tuser;
   logic            m_axis_tready;
   logic [1:0]      grant;
   logic            busy;
   logic [31:0]     frame_cnt;

   always #5 clk = ~clk;

   roce_tx_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .HDR_WIDTH(HW)) dut (
      .clk(clk), .resetn(resetn),
      .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready), .s_hdr_data(s_hdr_data),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
      .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready), .m_hdr_data(m_hdr_data),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
      .grant(grant), .busy(busy), .frame_cnt(frame_cnt)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [HW-1:0] srcHdr   [2][$];
   beat_t         srcBeats [2][$];
   beat_t         expBeats [2][$];

   bit            mOpen, mHdrDone, justReset;
   int            mRr, mPort;
   logic [HW-1:0] mHdr;
   logic [15:0]   mCnt [2];

   int            treadyMode, hdrLowLeft;
   bit            validRandom, hdrRandom;

   logic [1:0]    obsGrants[$];
   logic [1:0]    prevGrant;
   bit            prevHdrValid;
   int            obsBeatCnt, hdrValidCycles, acceptCyc, firstHdrCyc;
   logic [KW-1:0] lastKeepSeen;

   task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] randWide();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [15:0] grantSeq();
      logic [15:0] v = '0;
      for (int i = 0; i < obsGrants.size() && i < 8; i++) v[i*2 +: 2] = obsGrants[i];
      return v;
   endfunction

   function automatic bit pending();
      return mOpen || srcHdr[0].size() != 0 || srcHdr[1].size() != 0 ||
             expBeats[0].size() != 0 || expBeats[1].size() != 0;
   endfunction

   task automatic queueFrame(input int p, input int nBeats, input logic [KW-1:0] lastKeep);
      beat_t         b;
      logic [DW-1:0] h;
      h = randWide();
      srcHdr[p].push_back(h[HW-1:0]);
      for (int i = 0; i < nBeats; i++) begin
         b.data = randWide();
         b.keep = (i == nBeats - 1) ? lastKeep : '1;
         b.last = (i == nBeats - 1);
         b.user = 1'($urandom_range(0, 1));
         srcBeats[p].push_back(b);
         expBeats[p].push_back(b);
      end
   endtask

   task automatic applyStimulus();
      beat_t b;
      for (int p = 0; p < 2; p++) begin
         s_hdr_valid[p] = (srcHdr[p].size() != 0);
         s_hdr_data[p*HW +: HW] = '0;
         if (srcHdr[p].size() != 0) s_hdr_data[p*HW +: HW] = srcHdr[p][0];
         if (srcBeats[p].size() != 0 && (!validRandom || $urandom_range(0, 3) != 0)) begin
            b = srcBeats[p][0];
            s_axis_tvalid[p]        = 1'b1;
            s_axis_tdata[p*DW +: DW] = b.data;
            s_axis_tkeep[p*KW +: KW] = b.keep;
            s_axis_tlast[p]         = b.last;
            s_axis_tuser[p]         = b.user;
         end else begin
            s_axis_tvalid[p]        = 1'b0;
            s_axis_tdata[p*DW +: DW] = '0;
            s_axis_tkeep[p*KW +: KW] = '0;
            s_axis_tlast[p]         = 1'b0;
            s_axis_tuser[p]         = 1'b0;
         end
      end
      case (treadyMode)
         1:       m_axis_tready = ((cyc % 2) == 1);
         2:       m_axis_tready = ($urandom_range(0, 3) != 0);
         default: m_axis_tready = 1'b1;
      endcase
      if (mOpen && !mHdrDone && hdrLowLeft > 0) begin
         m_hdr_ready = 1'b0;
         hdrLowLeft--;
      end else begin
         m_hdr_ready = hdrRandom ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   // Check at the falling edge against the model, then advance the model by
   // the handshakes that the next rising edge will complete.
   task automatic stepCycle();
      logic [1:0] expReady;
      int         win;
      bit         inPayload, expTvalid;
      beat_t      b;
      @(negedge clk);
      cyc++;
      expReady = 2'b00;
      win = 0;
      if (resetn && !mOpen && s_hdr_valid != 2'b00) begin
         win = s_hdr_valid[mRr] ? mRr : 1 - mRr;
         expReady = (win == 1) ? 2'b10 : 2'b01;
      end
      inPayload = mOpen && mHdrDone;
      expTvalid = inPayload && s_axis_tvalid[mPort];

      checkOutput("s_hdr_ready", s_hdr_ready, expReady);
      checkOutput("busy", busy, mOpen);
      checkOutput("grant", grant, mOpen ? (1 << mPort) : 0);
      checkOutput("m_hdr_valid", m_hdr_valid, mOpen && !mHdrDone);
      if (mOpen && !mHdrDone) checkOutput("m_hdr_data", m_hdr_data, mHdr);
      if (justReset) checkOutput("m_hdr_data_reset", m_hdr_data, 0);
      checkOutput("m_axis_tvalid", m_axis_tvalid, expTvalid);
      checkOutput("s_axis_tready", s_axis_tready, (inPayload && m_axis_tready) ? (1 << mPort) : 0);
      checkOutput("frame_cnt", frame_cnt, {mCnt[1], mCnt[0]});
      if (expTvalid) begin
         if (expBeats[mPort].size() == 0) begin
            checkOutput("beat_available", 0, 1);
         end else begin
            b = expBeats[mPort][0];
            checkOutput("m_axis_tdata", m_axis_tdata, b.data);
            checkOutput("m_axis_tkeep", m_axis_tkeep, b.keep);
            checkOutput("m_axis_tlast", m_axis_tlast, b.last);
            checkOutput("m_axis_tuser", m_axis_tuser, b.user);
         end
      end

      if ((s_hdr_valid & s_hdr_ready) != 2'b00) acceptCyc = cyc;
      if (m_hdr_valid && !prevHdrValid) firstHdrCyc = cyc;
      prevHdrValid = m_hdr_valid;
      if (m_hdr_valid) hdrValidCycles++;
      if (grant != 2'b00 && grant != prevGrant) obsGrants.push_back(grant);
      prevGrant = grant;
      if (m_axis_tvalid && m_axis_tready) begin
         obsBeatCnt++;
         if (m_axis_tlast) lastKeepSeen = m_axis_tkeep;
      end

      if (!resetn) begin
         mOpen = 0; mHdrDone = 0; mRr = 0; mPort = 0; mHdr = '0;
         mCnt[0] = 16'd0; mCnt[1] = 16'd0;
         for (int p = 0; p < 2; p++) begin
            srcHdr[p].delete();
            srcBeats[p].delete();
            expBeats[p].delete();
         end
         justReset = 1;
      end else begin
         justReset = 0;
         if (mOpen && !mHdrDone) begin
            if (m_hdr_ready) mHdrDone = 1;
         end else if (expTvalid && m_axis_tready && expBeats[mPort].size() != 0) begin
            b = expBeats[mPort].pop_front();
            if (b.last) begin
               mOpen = 0;
               mCnt[mPort]++;
               mRr = 1 - mPort;
            end
         end
         if (expReady != 2'b00 && srcHdr[win].size() != 0) begin
            mOpen = 1; mHdrDone = 0; mPort = win; mHdr = srcHdr[win][0];
         end
         for (int p = 0; p < 2; p++) begin
            if (s_hdr_valid[p] && s_hdr_ready[p] && srcHdr[p].size() != 0) void'(srcHdr[p].pop_front());
            if (s_axis_tvalid[p] && s_axis_tready[p] && srcBeats[p].size() != 0) void'(srcBeats[p].pop_front());
         end
      end
      @(posedge clk);
      #1;
      applyStimulus();
   endtask

   task automatic doReset();
      resetn = 1'b0;
      stepCycle();
      stepCycle();
      resetn = 1'b1;
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      applyStimulus();
      while (pending() && n < budget) begin
         stepCycle();
         n++;
      end
      if (n >= budget) begin
         checkOutput({tag, "_timeout"}, 0, 1);
         doReset();
      end
      stepCycle();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      logic [KW-1:0] fullKeep;
      resetn = 1'b0;
      s_hdr_valid = '0; s_hdr_data = '0;
      s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0;
      m_hdr_ready = 1'b0; m_axis_tready = 1'b0;
      mOpen = 0; mHdrDone = 0; justReset = 0; mRr = 0; mPort = 0; mHdr = '0;
      mCnt[0] = 16'd0; mCnt[1] = 16'd0;
      treadyMode = 0; hdrLowLeft = 0; validRandom = 0; hdrRandom = 0;
      prevGrant = 2'b00; prevHdrValid = 0;
      obsBeatCnt = 0; hdrValidCycles = 0; acceptCyc = 0; firstHdrCyc = 0; lastKeepSeen = '0;
      fullKeep = '1;
      doReset();

      $display("[TB] single 3-beat frame on port 0");
      obsGrants.delete();
      obsBeatCnt = 0;
      queueFrame(0, 3, '1);
      drain("single", 200);
      checkOutput("single_hdr_latency", firstHdrCyc - acceptCyc, 1);
      checkOutput("single_beats", obsBeatCnt, 3);
      checkOutput("single_frame_cnt0", frame_cnt[15:0], 1);
      checkOutput("single_grants", {obsGrants.size(), grantSeq()}, {32'd1, 16'h0001});

      $display("[TB] simultaneous requests after reset");
      doReset();
      obsGrants.delete();
      queueFrame(0, 2, '1);
      queueFrame(1, 2, '1);
      drain("tie", 300);
      checkOutput("tie_grants", {obsGrants.size(), grantSeq()}, {32'd2, 16'b10_01});
      queueFrame(0, 1, '1);
      queueFrame(1, 1, '1);
      drain("tie_again", 300);
      checkOutput("tie_rr_back_to_0", {obsGrants.size(), grantSeq()}, {32'd4, 16'b10_01_10_01});

      $display("[TB] port 0 back-to-back with port 1 pending");
      obsGrants.delete();
      queueFrame(0, 2, '1);
      queueFrame(0, 3, '1);
      queueFrame(1, 2, '1);
      drain("alternate", 400);
      checkOutput("alternate_grants", {obsGrants.size(), grantSeq()}, {32'd3, 16'b01_10_01});

      $display("[TB] 32-beat frame with toggling tready");
      treadyMode = 1;
      obsBeatCnt = 0;
      queueFrame(0, 32, 64'h000000FFFFFFFFFF);
      drain("toggle", 400);
      checkOutput("toggle_beats", obsBeatCnt, 32);
      checkOutput("toggle_last_keep", lastKeepSeen, 64'h000000FFFFFFFFFF);
      treadyMode = 0;

      $display("[TB] header backpressure for 5 cycles");
      hdrLowLeft = 5;
      hdrValidCycles = 0;
      queueFrame(1, 4, '1);
      drain("hdr_stall", 200);
      checkOutput("hdr_stall_valid_cycles", hdrValidCycles, 6);

      $display("[TB] reset in the middle of a frame");
      obsBeatCnt = 0;
      queueFrame(0, 32, '1);
      applyStimulus();
      n = 0;
      while (obsBeatCnt < 10 && n < 500) begin
         stepCycle();
         n++;
      end
      checkOutput("midreset_reach_beat10", obsBeatCnt, 10);
      resetn = 1'b0;
      stepCycle();
      stepCycle();
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_grant", grant, 0);
      checkOutput("midreset_m_axis_tvalid", m_axis_tvalid, 0);
      checkOutput("midreset_s_axis_tready", s_axis_tready, 0);
      checkOutput("midreset_frame_cnt", frame_cnt, 0);
      resetn = 1'b1;
      queueFrame(0, 3, '1);
      drain("after_reset", 200);
      checkOutput("after_reset_frame_cnt", frame_cnt, 32'h0000_0001);

      $display("[TB] randomized traffic");
      treadyMode = 2;
      validRandom = 1;
      hdrRandom = 1;
      for (int r = 0; r < 12; r++) begin
         int k;
         k = $urandom_range(1, 4);
         for (int f = 0; f < k; f++) begin
            queueFrame($urandom_range(0, 1), $urandom_range(1, 8), fullKeep >> $urandom_range(0, KW - 1));
         end
         drain("random", 3000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
